day6_seq_divider: RTL

//   Sequential unsigned restoring divider: the inverse of the 4-bit array

---
 rtl/day6_seq_divider.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/day6_seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, behind a
// start/busy/done handshake. Divide-by-zero takes one cycle and returns all-ones.
module day6_seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] div_r;
    logic             zero_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;

    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH:0]   diff_s;
    logic             fits_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] q_next_s;

    // One restoring step on the partial remainder and quotient shift register.
    always_comb begin
        rem_shift_s = {rem_r, q_r[WIDTH-1]};
        diff_s      = rem_shift_s - {1'b0, div_r};
        // rem_r < div_r keeps R'-D within +/-2^WIDTH, so the top bit is the borrow.
        fits_s      = ~diff_s[WIDTH];
        if (fits_s) begin
            rem_next_s = diff_s[WIDTH-1:0];
        end else begin
            rem_next_s = rem_shift_s[WIDTH-1:0];
        end
        q_next_s = {q_r[WIDTH-2:0], fits_s};
    end

    // Next-state logic; a zero divisor spends its single CALC cycle loading the result.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_in) begin
                    next_state_s = ST_CALC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (zero_r || (count_r == {CW{1'b0}})) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_CALC;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register with registered busy/done decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
            done_r  <= (next_state_s == ST_DONE);
        end
    end

    // Operand capture, iteration registers and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r     <= {CW{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            q_r         <= {WIDTH{1'b0}};
            div_r       <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_in) begin
                        count_r <= CW'(WIDTH - 1);
                        rem_r   <= {WIDTH{1'b0}};
                        q_r     <= dividend_in;
                        div_r   <= divisor_in;
                        zero_r  <= (divisor_in == {WIDTH{1'b0}});
                        dbz_r   <= 1'b0;
                    end
                end
                ST_CALC: begin
                    if (zero_r) begin
                        // q_r still holds the untouched dividend here.
                        quotient_r  <= {WIDTH{1'b1}};
                        remainder_r <= q_r;
                        dbz_r       <= 1'b1;
                    end else begin
                        q_r   <= q_next_s;
                        rem_r <= rem_next_s;
                        if (count_r == {CW{1'b0}}) begin
                            quotient_r  <= q_next_s;
                            remainder_r <= rem_next_s;
                        end else begin
                            count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule
